// File: rtl/sub_corr_pipe.sv
// Two-stage correction adder: S1 looks up a per-index constant from a writable
// table, S2 adds it to the partial result and reports the carry out.
module sub_corr_pipe #(
  parameter int unsigned W  = 40,
  parameter int unsigned MB = 4,
  parameter logic [W-1:0] K = W'(40'h05BFC65FEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MB-1:0] in_m,
  input  logic [W-1:0]  in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic          out_carry,
  input  logic          wr_en,
  input  logic [MB-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          tbl_restore
);

  localparam int unsigned DEPTH = 1 << MB;

  // Default entry: 0 for index 0, otherwise 2^(W-1) - (i-1)*K, all mod 2^W.
  function automatic logic [W-1:0] dflt(input int unsigned i);
    logic [W-1:0] half;
    half        = '0;
    half[W-1]   = 1'b1;
    if (i == 0) return '0;
    return half - (W'(i - 1) * K);
  endfunction

  logic [W-1:0] tbl [DEPTH];

  logic         stall_c;
  logic         s1_valid;
  logic [W-1:0] s1_x;
  logic [W-1:0] s1_c;
  logic [W:0]   sum_c;

  assign stall_c  = out_valid & ~out_ready;
  assign in_ready = ~stall_c;
  assign sum_c    = {1'b0, s1_x} + {1'b0, s1_c};

  // Correction table; restore beats a same-cycle write, reads see the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[MB'(i)] <= dflt(i);
    end else if (tbl_restore) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[MB'(i)] <= dflt(i);
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  // S1: capture operand and looked-up constant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_c     <= '0;
    end else if (!stall_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x <= in_x;
        s1_c <= tbl[in_m];
      end
    end
  end

  // S2: registered sum and carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
    end else if (!stall_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum   <= sum_c[W-1:0];
        out_carry <= sum_c[W];
      end
    end
  end

endmodule

// File: tb/tb_sub_corr_pipe.sv
// Directed bench for sub_corr_pipe: single-beat vector table, backpressured
// stream, write/restore ordering and asynchronous reset mid-stream.
module tb_sub_corr_pipe;

  localparam int unsigned W  = 40;
  localparam int unsigned MB = 4;
  localparam logic [W-1:0] K = 40'h05BFC65FEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [MB-1:0] in_m;
  logic [W-1:0]  in_x;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_carry;
  logic          wr_en;
  logic [MB-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          tbl_restore;

  int tests = 0;
  int fails = 0;

  sub_corr_pipe #(.W(W), .MB(MB), .K(K)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .tbl_restore(tbl_restore)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MB-1:0] m;
    logic [W-1:0]  x;
    logic [W-1:0]  sum;
    logic          carry;
  } vec_t;

  // Reference default entry, built by repeated subtraction of K.
  function automatic logic [W-1:0] ref_dflt(input int i);
    logic [W-1:0] v;
    if (i == 0) return '0;
    v = 40'h8000000000;
    for (int j = 1; j < i; j++) v = v - K;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, then check latency and result.
  task automatic single_beat(input string name, input logic [MB-1:0] m, input logic [W-1:0] x,
                             input logic [W-1:0] es, input logic ec);
    in_valid = 1'b1; in_m = m; in_x = x;
    tick();
    in_valid = 1'b0;
    chk({name, "_early"}, 64'(out_valid), 64'd0);
    tick();
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_sum"}, 64'(out_sum), 64'(es));
    chk({name, "_carry"}, 64'(out_carry), 64'(ec));
  endtask

  vec_t vecs [6];
  logic [W-1:0] exp_q [$];

  initial begin
    vecs[0] = '{m: 4'd0,  x: 40'h123,        sum: 40'h123,        carry: 1'b0};
    vecs[1] = '{m: 4'd2,  x: 40'h1,          sum: 40'h7a4039a012, carry: 1'b0};
    vecs[2] = '{m: 4'd15, x: 40'hD07CD93F12, sum: 40'h0,          carry: 1'b1};
    vecs[3] = '{m: 4'd1,  x: 40'h8000000000, sum: 40'h0,          carry: 1'b1};
    vecs[4] = '{m: 4'd1,  x: 40'h0,          sum: 40'h8000000000, carry: 1'b0};
    vecs[5] = '{m: 4'd15, x: 40'h0,          sum: 40'h2f8326c0ee, carry: 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_m = '0; in_x = '0; out_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; tbl_restore = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_carry", 64'(out_carry), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Vector table
    for (int i = 0; i < 6; i++)
      single_beat($sformatf("vec%0d", i), vecs[i].m, vecs[i].x, vecs[i].sum, vecs[i].carry);
    tick();

    // Streaming 16 beats under random backpressure
    for (int i = 0; i < 16; i++) exp_q.push_back(ref_dflt(i));
    begin
      int idx = 0;
      int got = 0;
      int cyc = 0;
      while (got < 16 && cyc < 500) begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = (idx < 16);
        in_m      = MB'(idx);
        in_x      = '0;
        #1;
        chk("stream_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (out_valid && out_ready) begin
          chk($sformatf("stream_sum%0d", got), 64'(out_sum), 64'(exp_q[got]));
          got++;
        end
        if (in_valid && in_ready) idx++;
        cyc++;
        tick();
      end
      chk("stream_count", 64'(got), 64'd16);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("stream_drained", 64'(out_valid), 64'd0);
      tick(); tick();
      chk("stream_no_dup", 64'(out_valid), 64'd0);
    end

    // Same-cycle write to the looked-up entry: old value, then new
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 40'hFFFFFFFFFF;
    in_valid = 1'b1; in_m = 4'd3; in_x = 40'h1;
    tick();
    wr_en = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("coll_first_valid", 64'(out_valid), 64'd1);
    chk("coll_first_sum", 64'(out_sum), 64'h7480734023);
    chk("coll_first_carry", 64'(out_carry), 64'd0);
    tick();
    chk("coll_second_valid", 64'(out_valid), 64'd1);
    chk("coll_second_sum", 64'(out_sum), 64'h0);
    chk("coll_second_carry", 64'(out_carry), 64'd1);
    tick();

    // Restore wins over a same-cycle write
    tbl_restore = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_data = '0;
    tick();
    tbl_restore = 1'b0; wr_en = 1'b0;
    single_beat("restore_e5", 4'd5, 40'h0, 40'h6900e68044, 1'b0);
    single_beat("restore_e3", 4'd3, 40'h1, 40'h7480734023, 1'b0);
    tick();

    // Async reset with two beats in flight under stall
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 40'h123;
    tick();
    wr_en = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_m = 4'd0; in_x = 40'h5;
    tick();
    in_m = 4'd0; in_x = 40'h6;
    tick();
    in_valid = 1'b0;
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("arst_no_stale%0d", i), 64'(out_valid), 64'd0);
    end
    single_beat("arst_e7_default", 4'd7, 40'h0, 40'h5d8159c066, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
